seg_decode_rx: RTL
==================

SEG_DECODE_RX -- requirements
Module: seg_decode_rx

Interface
REQ-001 The module SHALL have a parameter STABLE_CYC, default 4, giving the number of consecutive identical samples required before a capture (legal range 1..255).
REQ-002 The module SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have a port seg_in, input, 8 bits: one digit segment pattern; bit7 is dp, bits6..0 are segments g..a, active-high.
REQ-005 The module SHALL have a port e1_in, input, 1 bit: the left-digit enable.
REQ-006 The module SHALL have a port e0_in, input, 1 bit: the right-digit enable.
REQ-007 The module SHALL have a port out_valid, output, 1 bit: a decoded digit is presented.
REQ-008 The module SHALL have a port out_ready, input, 1 bit: the consumer accepts the digit.
REQ-009 The module SHALL have a port out_side, output, 1 bit: 1 = left (e1), 0 = right (e0).
REQ-010 The module SHALL have a port out_val, output, 4 bits: the decoded hex value.
REQ-011 The module SHALL have a port out_err, output, 1 bit: the pattern is not in the decode table.
REQ-012 The module SHALL have a port out_dp, output, 1 bit: the decimal-point flag (see Configuration).
REQ-013 The module SHALL have a port digit_left, output, 4 bits: the last accepted left value.
REQ-014 The module SHALL have a port digit_right, output, 4 bits: the last accepted right value.

Function
REQ-015 The sample word SHALL be {e1_in, e0_in, seg_in}, registered once per cycle, with stability judged on registered samples only.
REQ-016 A sample SHALL be qualified only when exactly one of e1_in and e0_in is high; if both or neither are high, the FSM SHALL return to IDLE and the stability counter SHALL clear.
REQ-017 The FSM SHALL implement the states IDLE, SETTLE, PRESENT and WAIT_CHANGE.
REQ-018 In IDLE, a qualified sample SHALL latch the sample, load the counter with 1, and move to SETTLE.
REQ-019 In SETTLE, a sample equal to the latched sample SHALL increment the counter, and the FSM SHALL go to PRESENT when the count reaches STABLE_CYC; a differing qualified sample SHALL relatch and reset the count to 1.
REQ-020 With STABLE_CYC=1, the FSM SHALL go from IDLE directly to PRESENT.
REQ-021 out_valid SHALL rise exactly STABLE_CYC+1 cycles after the first registered qualified sample.
REQ-022 Decode SHALL use bits6..0: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
REQ-023 Any other pattern SHALL give out_err=1 and out_val=0.
REQ-024 In PRESENT, out_valid SHALL be 1, and out_side, out_val, out_err and out_dp SHALL hold constant until a cycle with out_valid and out_ready both high.
REQ-025 On handshake, the FSM SHALL go to WAIT_CHANGE and update digit_left or digit_right per out_side, only when out_err=0.
REQ-026 Input changes while in PRESENT SHALL NOT alter presented data.
REQ-027 If out_ready is already high on PRESENT entry, transfer SHALL occur that cycle, so out_valid is high for 1 cycle.
REQ-028 In WAIT_CHANGE, a sample equal to the last accepted sample SHALL NOT produce a new capture; a differing qualified sample SHALL go to SETTLE, and an unqualified sample SHALL go to IDLE.
REQ-029 Left/right alternation SHALL count as a change.

Reset
REQ-030 rst high SHALL asynchronously force the FSM to IDLE, clear the counter and sample registers, and drive out_valid=0, out_side=0, out_val=0, out_err=0, out_dp=0, digit_left=0, digit_right=0.
REQ-031 Reset asserted in PRESENT SHALL drop out_valid immediately, and the pending digit SHALL be lost.
REQ-032 After deassertion, the first capture SHALL require a full STABLE_CYC settle.

Configuration
REQ-033 When macro SEG_DECODE_DP_EN is defined, out_dp SHALL equal the captured seg_in bit7, and bit7 SHALL take part in stability and change detection.
REQ-034 When SEG_DECODE_DP_EN is undefined, out_dp SHALL be tied 0, and bit7 SHALL be masked to 0 before the sample register.

Verification
REQ-035 The bench SHALL cover: STABLE_CYC=4, e1=1, e0=0, seg=0x06 held, out_ready=1 -> one out_valid pulse 5 cycles after first sample, side=1, val=1, err=0, digit_left=1.
REQ-036 The bench SHALL cover: e0=1, seg=0x71, out_ready=0 for 10 cycles then 1 -> out_valid held 10+ cycles, data stable, val=F, side=0, digit_right=F after handshake.
REQ-037 The bench SHALL cover: e1=1, seg=0x3F for 2 cycles then 0x4F held -> single capture val=3, no capture of 0.
REQ-038 The bench SHALL cover: e1=e0=1, seg=0x7F for 20 cycles -> out_valid never asserts; then e1=1, e0=0, seg=0x00 held -> err=1, val=0, digit_left unchanged.
REQ-039 The bench SHALL cover: alternating e1 (seg=0x5B) and e0 (seg=0x66), each held 6 cycles, out_ready=1 -> captures side1/2, side0/4, repeating; the same word held 50 cycles -> one capture only.
REQ-040 The bench SHALL cover: rst pulsed mid-PRESENT -> out_valid=0 in the same cycle and all outputs 0; with SEG_DECODE_DP_EN, seg=0x86 -> val=1, dp=1.

Source files
------------

// File: rtl/seg_decode_rx.sv
// Seven-segment digit receiver: debounces a multiplexed {e1,e0,seg} sample word,
// decodes it to hex and hands it off with a valid/ready handshake.
// Optional decimal-point capture is enabled by defining SEG_DECODE_DP_EN.
module seg_decode_rx #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       e1_in,
  input  logic       e0_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_side,
  output logic [3:0] out_val,
  output logic       out_err,
  output logic       out_dp,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SETTLE      = 2'd1;
  localparam logic [1:0] PRESENT     = 2'd2;
  localparam logic [1:0] WAIT_CHANGE = 2'd3;

  localparam logic [7:0] STABLE = 8'(STABLE_CYC);

  logic [1:0] state, state_nx;
  logic [9:0] samp, held, held_nx;
  logic [7:0] cnt, cnt_nx;
  logic       load;
  logic       qual;
  logic       dp_bit;
  logic [3:0] dec_val;
  logic       dec_err;

`ifdef SEG_DECODE_DP_EN
  assign dp_bit = seg_in[7];
`else
  assign dp_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp <= '0;
    else     samp <= {e1_in, e0_in, dp_bit, seg_in[6:0]};
  end

  assign qual      = samp[9] ^ samp[8];
  assign out_valid = (state == PRESENT);

  // The decoder always looks at the registered sample; when a capture fires it
  // equals the latched word, so one decoder serves both capture paths.
  always_comb begin
    dec_err = 1'b0;
    dec_val = 4'h0;
    case (samp[6:0])
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    held_nx  = held;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (qual) begin
          held_nx = samp;
          cnt_nx  = 8'd1;
          if (STABLE <= 8'd1) begin
            state_nx = PRESENT;
            load     = 1'b1;
          end else begin
            state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!qual) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (samp == held) begin
          cnt_nx = cnt + 8'd1;
          if (cnt_nx >= STABLE) begin
            state_nx = PRESENT;
            load     = 1'b1;
          end
        end else begin
          held_nx = samp;
          cnt_nx  = 8'd1;
        end
      end
      PRESENT: begin
        if (out_ready) state_nx = WAIT_CHANGE;
      end
      WAIT_CHANGE: begin
        // held still carries the last accepted word, so only a real change re-arms
        if (!qual) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (samp != held) begin
          held_nx = samp;
          cnt_nx  = 8'd1;
          if (STABLE <= 8'd1) begin
            state_nx = PRESENT;
            load     = 1'b1;
          end else begin
            state_nx = SETTLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      held        <= '0;
      cnt         <= '0;
      out_side    <= 1'b0;
      out_val     <= 4'h0;
      out_err     <= 1'b0;
      out_dp      <= 1'b0;
      digit_left  <= 4'h0;
      digit_right <= 4'h0;
    end else begin
      state <= state_nx;
      held  <= held_nx;
      cnt   <= cnt_nx;
      if (load) begin
        out_side <= samp[9];
        out_val  <= dec_val;
        out_err  <= dec_err;
        out_dp   <= samp[7];
      end
      if (out_valid && out_ready && !out_err) begin
        if (out_side) digit_left  <= out_val;
        else          digit_right <= out_val;
      end
    end
  end

endmodule
